// File: rtl/midi_voice_alloc_if.sv
`default_nettype none
// ============================================================================
//  Module   : midi_voice_alloc_if
//  Purpose  : Channel-message bus between the MIDI receiver (master) and the
//             voice allocator (slave). The message is a 3-byte triple
//             qualified by a one-cycle cmd_ready strobe.
//  Revision : 1.0 - initial release
// ============================================================================
interface midi_voice_alloc_if;
  logic       cmd_ready;
  logic [7:0] byte1;
  logic [7:0] byte2;
  logic [7:0] byte3;

  modport master (output cmd_ready, output byte1, output byte2, output byte3);
  modport slave  (input  cmd_ready, input  byte1, input  byte2, input  byte3);
endinterface
`default_nettype wire

// File: rtl/midi_voice_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : midi_voice_alloc
//  Purpose  : Polyphonic voice allocator. Decodes note-on / note-off /
//             all-notes-off channel messages and assigns them to voice slots
//             (lowest free slot first), keeping an age rank per active slot.
//             Optional build macro VOICE_STEAL_EN: a note-on arriving while
//             every slot is busy steals the oldest slot instead of being
//             dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module midi_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int CHANNEL    = 0,
  parameter int RANK_W     = 4
) (
  input  wire logic                      clk,
  input  wire logic                      rst,   // asynchronous, active low
  midi_voice_alloc_if.slave              cmd,
  output logic [NUM_VOICES-1:0]          voice_gate,
  output logic [7*NUM_VOICES-1:0]        voice_note,
  output logic [7*NUM_VOICES-1:0]        voice_vel,
  output logic [NUM_VOICES-1:0]          voice_trig,
  output logic                           drop_pulse
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {
    OP_NONE     = 2'd0,
    OP_NOTE_ON  = 2'd1,
    OP_NOTE_OFF = 2'd2,
    OP_ALL_OFF  = 2'd3
  } op_t;

  // Stage-1 registers (decoded message)
  logic       r_s1_valid;
  op_t        r_s1_op;
  logic [6:0] r_s1_note;
  logic [6:0] r_s1_vel;

  // Voice state
  logic [NUM_VOICES-1:0] r_gate;
  logic [6:0]            r_note [NUM_VOICES];
  logic [6:0]            r_vel  [NUM_VOICES];
  logic [RANK_W-1:0]     r_rank [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_trig;
  logic                  r_drop;

  // Next-state values
  op_t                   w_op;
  logic [NUM_VOICES-1:0] w_gate_nx;
  logic [6:0]            w_note_nx [NUM_VOICES];
  logic [6:0]            w_vel_nx  [NUM_VOICES];
  logic [RANK_W-1:0]     w_rank_nx [NUM_VOICES];
  logic [NUM_VOICES-1:0] w_trig_nx;
  logic                  w_drop_nx;

  // Slot search results
  logic                  w_hit;
  logic [IDX_W-1:0]      w_hit_idx;
  logic [RANK_W-1:0]     w_hit_rank;
  logic                  w_free;
  logic [IDX_W-1:0]      w_free_idx;
`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0]      w_old_idx;
`endif

  // Bit 7 of the data bytes carries no information in a channel message.
  logic w_unused;
  assign w_unused = &{1'b0, cmd.byte2[7], cmd.byte3[7]};

  // Decode the status byte into an operation; foreign channels decode to none.
  always_comb begin
    w_op = OP_NONE;
    if (cmd.byte1[3:0] == 4'(CHANNEL)) begin
      case (cmd.byte1[7:4])
        4'h9:    w_op = (cmd.byte3[6:0] != 7'd0) ? OP_NOTE_ON : OP_NOTE_OFF;
        4'h8:    w_op = OP_NOTE_OFF;
        4'hB:    w_op = (cmd.byte2[6:0] == 7'd123) ? OP_ALL_OFF : OP_NONE;
        default: w_op = OP_NONE;
      endcase
    end
  end

  // Stage 1: capture the decoded message on the ready strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_NONE;
      r_s1_note  <= 7'd0;
      r_s1_vel   <= 7'd0;
    end else begin
      r_s1_valid <= cmd.cmd_ready;
      if (cmd.cmd_ready) begin
        r_s1_op   <= w_op;
        r_s1_note <= cmd.byte2[6:0];
        r_s1_vel  <= cmd.byte3[6:0];
      end
    end
  end

  // Locate the active slot holding the message note and the lowest free slot.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!w_hit && r_gate[i] && (r_note[i] == r_s1_note)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
      if (!w_free && !r_gate[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
    w_hit_rank = r_rank[w_hit_idx];
  end

`ifdef VOICE_STEAL_EN
  // With every slot busy, the oldest voice carries the highest rank.
  always_comb begin
    w_old_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (r_rank[i] == RANK_W'(NUM_VOICES - 1)) begin
        w_old_idx = IDX_W'(i);
      end
    end
  end
`endif

  // Stage 2: apply the decoded operation to the voice pool and age ranks.
  always_comb begin
    w_gate_nx = r_gate;
    w_trig_nx = '0;
    w_drop_nx = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_note_nx[i] = r_note[i];
      w_vel_nx[i]  = r_vel[i];
      w_rank_nx[i] = r_rank[i];
    end
    if (r_s1_valid) begin
      case (r_s1_op)
        OP_NOTE_ON: begin
          if (w_hit) begin
            // Retrigger: voices younger than this one age by one.
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (r_gate[i] && (r_rank[i] < w_hit_rank)) begin
                w_rank_nx[i] = r_rank[i] + 1'b1;
              end
            end
            w_rank_nx[w_hit_idx] = '0;
            w_vel_nx[w_hit_idx]  = r_s1_vel;
            w_trig_nx[w_hit_idx] = 1'b1;
          end else if (w_free) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (r_gate[i]) begin
                w_rank_nx[i] = r_rank[i] + 1'b1;
              end
            end
            w_gate_nx[w_free_idx] = 1'b1;
            w_note_nx[w_free_idx] = r_s1_note;
            w_vel_nx[w_free_idx]  = r_s1_vel;
            w_rank_nx[w_free_idx] = '0;
            w_trig_nx[w_free_idx] = 1'b1;
          end else begin
`ifdef VOICE_STEAL_EN
            // All slots busy: every voice ages, the oldest is overwritten.
            for (int i = 0; i < NUM_VOICES; i++) begin
              w_rank_nx[i] = r_rank[i] + 1'b1;
            end
            w_note_nx[w_old_idx] = r_s1_note;
            w_vel_nx[w_old_idx]  = r_s1_vel;
            w_rank_nx[w_old_idx] = '0;
            w_trig_nx[w_old_idx] = 1'b1;
`else
            w_drop_nx = 1'b1;
`endif
          end
        end
        OP_NOTE_OFF: begin
          if (w_hit) begin
            // Release: voices older than this one close the rank gap.
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (r_gate[i] && (r_rank[i] > w_hit_rank)) begin
                w_rank_nx[i] = r_rank[i] - 1'b1;
              end
            end
            w_gate_nx[w_hit_idx] = 1'b0;
            w_rank_nx[w_hit_idx] = '0;
          end
        end
        OP_ALL_OFF: begin
          w_gate_nx = '0;
          for (int i = 0; i < NUM_VOICES; i++) begin
            w_rank_nx[i] = '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Voice state register; strobes last exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gate <= '0;
      r_trig <= '0;
      r_drop <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i] <= 7'd0;
        r_vel[i]  <= 7'd0;
        r_rank[i] <= '0;
      end
    end else begin
      r_gate <= w_gate_nx;
      r_trig <= w_trig_nx;
      r_drop <= w_drop_nx;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i] <= w_note_nx[i];
        r_vel[i]  <= w_vel_nx[i];
        r_rank[i] <= w_rank_nx[i];
      end
    end
  end

  assign voice_gate = r_gate;
  assign voice_trig = r_trig;
  assign drop_pulse = r_drop;

  generate
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
      assign voice_note[7*g +: 7] = r_note[g];
      assign voice_vel[7*g +: 7]  = r_vel[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/midi_voice_alloc.md
Name: midi_voice_alloc

Overview:
- Polyphonic voice allocator directly downstream of the MIDI receiver.
- Consumes the receiver's 3-byte channel message (status, data1, data2) and its one-cycle ready strobe.
- Tracks note-on/note-off per voice slot and drives per-voice note, velocity, gate and retrigger strobes into the synth voice oscillators/envelopes.
- Voice pool is allocated lowest-free-first, with age ranking kept for optional oldest-voice stealing.

Parameters:
- NUM_VOICES, 4: number of voice slots; legal range 2..16.
- CHANNEL, 0: MIDI channel (0..15) this block responds to; byte1[3:0] must match.
- RANK_W, 4: width of per-voice age rank; must satisfy 2^RANK_W >= NUM_VOICES.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous active-low reset.
- cmd_ready  in  1  one-cycle strobe: byte1..byte3 hold a complete message.
- byte1  in  8  status byte.
- byte2  in  8  data byte 1 (note number / controller).
- byte3  in  8  data byte 2 (velocity / value).
- voice_gate  out  NUM_VOICES  1 = slot holds a sounding note.
- voice_note  out  7*NUM_VOICES  note number per slot; slot i at [7i+6:7i].
- voice_vel  out  7*NUM_VOICES  velocity per slot, same packing.
- voice_trig  out  NUM_VOICES  one-cycle strobe when a slot is (re)started.
- drop_pulse  out  1  one-cycle strobe when a note-on is discarded.

Behaviour:
- Reset (rst=0, async): all outputs 0, all ranks 0, pipeline valid flags 0. Reset mid-message discards the message with no output strobes.
- Stage 1 (edge where cmd_ready=1): latch and decode byte1..3 into a 1-bit valid plus an op code.
  - NOTE_ON: byte1[7:4]=9, byte3[6:0]!=0.
  - NOTE_OFF: byte1[7:4]=8, or byte1[7:4]=9 with byte3[6:0]=0.
  - ALL_OFF: byte1[7:4]=B and byte2[6:0]=123.
  - Anything else, or byte1[3:0]!=CHANNEL: op NONE.
- Stage 2 (next edge): apply the op to the voice state. Latency from cmd_ready to output change is 2 clk edges.
- cmd_ready may assert on consecutive cycles; each message is applied in order, one per cycle, and none is lost.
- voice_trig and drop_pulse are high for exactly the stage-2 cycle of the message that caused them, and are 0 otherwise.
- NOTE_ON:
  - If an active slot already holds the note: retrigger that slot. Update vel, pulse its trig, set its rank to 0, increment ranks of active slots whose rank was below its old rank.
  - Else, if a free slot exists: take the lowest-index free slot. Gate=1, load note/vel, pulse trig, rank 0, all other active slots rank+1.
  - Else (all slots busy): handled by the optional feature.
- NOTE_OFF:
  - If an active slot holds the note: gate=0 and decrement ranks of active slots with rank greater than the released slot's rank. Note/vel keep their last value so envelope release can use them.
  - If no slot holds the note: no change and no pulse.
- ALL_OFF: all gates 0 and all ranks 0 in one cycle; note/vel unchanged.
- Invariants:
  - Active slot ranks are always a permutation of 0..k-1, where k = number of active slots.
  - At most one active slot holds any given note number.
- Data bytes use [6:0] only; bit 7 is ignored.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: a NOTE_ON with all slots busy steals the slot with rank NUM_VOICES-1 (the oldest). That slot loads the new note/vel, gate stays 1, trig pulses, rank becomes 0 and all other ranks +1. drop_pulse stays 0.
- Undefined: that NOTE_ON is discarded, state is unchanged, and drop_pulse pulses for one cycle.
- The rank logic is still required when the macro is undefined, for retrigger and release bookkeeping.

Test Plan:
- Reset, then note-on 0x90,60,100 -> 2 edges later gate=0001, note0=60, vel0=100, trig=0001 for one cycle.
- Note-ons 60, 64, 67 then note-off 0x80,64 -> gate=0101; slot1 note stays 64; then note-on 72 -> goes to slot1, gate=0111.
- Note-on 0x91,60,100 with CHANNEL=0, and 0x90,60,0 after 60 is active -> first gives no change; second clears gate0 (velocity-0 treated as note-off).
- 5 note-ons 60,62,64,65,67 with NUM_VOICES=4:
  - With VOICE_STEAL_EN: slot0 becomes 67, trig=0001, drop_pulse=0.
  - Without it: notes unchanged, drop_pulse=1 for one cycle.
- Four active voices, then 0xB0,123,0 -> gate=0000 in one cycle. Back-to-back cmd_ready on 2 consecutive cycles (note-on 60, note-on 62) -> both applied, gate=0011.
- Assert rst low while a message is in stage 1 -> all outputs 0 immediately, and no trig after rst is released.
